// File: rtl/outport_uart_logger_pkg.sv
// rtl/outport_uart_logger_pkg.sv - shared types and helpers for the outport UART logger
package outlog_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // Clock cycles per serial bit; integer division truncates any remainder.
  function automatic int divisor(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/outport_uart_logger_if.sv
// rtl/outport_uart_logger_if.sv - outport capture inputs and serial/status outputs
interface outport_uart_logger_if #(
  parameter int n     = 8,
  parameter int DEPTH = 8
);
  logic [n-1:0]            data_in;
  logic                    enable;
  logic                    tx;
  logic                    busy;
  logic                    overflow;
  logic [$clog2(DEPTH):0]  count;

  modport master (output data_in, enable, input tx, busy, overflow, count);
  modport slave  (input data_in, enable, output tx, busy, overflow, count);
endinterface

// File: rtl/outport_uart_logger_uart_tx.sv
// rtl/outport_uart_logger_uart_tx.sv - 8N1 serialiser with baud counter and registered line
module uart_tx
  import outlog_pkg::*;
#(
  parameter int n       = 8,
  parameter int DIVISOR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] data,
  output logic         ready,
  output logic         tx
);

  localparam int CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int IDX_W = (n > 1) ? $clog2(n) : 1;

  tx_state_t        state, state_d;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_d;
  logic [IDX_W-1:0] bit_idx, bit_idx_d;
  logic [n-1:0]     shift, shift_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             bit_end;

  assign bit_end = (baud_cnt == CNT_W'(DIVISOR - 1));
  assign tx      = tx_q;
  assign ready   = ready_q;

  // Next-state and next line value; tx is computed one step ahead so the pin is a flop.
  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt;
    bit_idx_d  = bit_idx;
    shift_d    = shift;
    tx_d       = tx_q;
    case (state)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (start) begin
          state_d    = TX_START;
          shift_d    = data;
          bit_idx_d  = '0;
          baud_cnt_d = '0;
          tx_d       = 1'b0;
        end
      end
      TX_START: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          state_d    = TX_DATA;
          tx_d       = shift[0];
        end else begin
          baud_cnt_d = baud_cnt + 1'b1;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          if (bit_idx == IDX_W'(n - 1)) begin
            state_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d   = shift >> 1;
            bit_idx_d = bit_idx + 1'b1;
            tx_d      = shift[1];
          end
        end else begin
          baud_cnt_d = baud_cnt + 1'b1;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          state_d    = TX_IDLE;
          tx_d       = 1'b1;
        end else begin
          baud_cnt_d = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    ready_d = (state_d == TX_IDLE);
  end

  // State register; reset drops any frame in flight and parks the line high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_idx  <= bit_idx_d;
      shift    <= shift_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
    end
  end

endmodule

// File: rtl/outport_uart_logger.sv
// rtl/outport_uart_logger.sv - logs every outport value change as a UART byte via a FIFO
module outport_uart_logger
  import outlog_pkg::*;
#(
  parameter int n      = 8,
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  outport_uart_logger_if.slave  bus
);

  localparam int DIVISOR = divisor(CLK_HZ, BAUD);
  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;

  logic [n-1:0]  prev;
  logic [n-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          push, pop, wr_en, full, empty, tx_ready;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.enable && (bus.data_in != prev);
  assign pop   = tx_ready && !empty;
  // A pop frees the slot this cycle, so a push into a full FIFO still lands.
  assign wr_en = push && (!full || pop);

  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = !tx_ready;

  // Change detector history, FIFO pointers/occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      prev <= bus.data_in;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push && !wr_en) overflow_q <= 1'b1;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.data_in;
  end

  uart_tx #(
    .n       (n),
    .DIVISOR (DIVISOR)
  ) u_uart_tx (
    .clk   (clk),
    .reset (reset),
    .start (pop),
    .data  (mem[rd_ptr]),
    .ready (tx_ready),
    .tx    (bus.tx)
  );

endmodule
